// File: rtl/seq_wide_adder_pkg.sv
// Shared definitions for seq_wide_adder: FSM states, slice geometry and
// the sizing helper for the word index counter.
package seq_wide_adder_pkg;

  localparam int SLICE_W  = 32;
  localparam int SLICE_LG = $clog2(SLICE_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // A single-word build still needs a 1-bit index register.
  function automatic int idxWidth(input int words);
    return (words <= 1) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/seq_wide_adder_csa32bits.sv
// 32-bit carry-select adder: the upper half is precomputed for both possible
// carries out of the lower half and selected once that carry resolves.
module csa32bits (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] s,
  output logic        cout
);

  logic [16:0] loSum;
  logic [16:0] hiSum0;
  logic [16:0] hiSum1;

  assign loSum  = {1'b0, a[15:0]} + {1'b0, b[15:0]} + {16'd0, cin};
  assign hiSum0 = {1'b0, a[31:16]} + {1'b0, b[31:16]};
  assign hiSum1 = {1'b0, a[31:16]} + {1'b0, b[31:16]} + 17'd1;

  assign s    = {(loSum[16] ? hiSum1[15:0] : hiSum0[15:0]), loSum[15:0]};
  assign cout = loSum[16] ? hiSum1[16] : hiSum0[16];

endmodule

// File: rtl/seq_wide_adder.sv
// Multi-cycle W-bit adder: walks the operands one 32-bit word per cycle,
// LSW first, through a single csa32bits with the carry held in a register.
module seq_wide_adder
  import seq_wide_adder_pkg::*;
#(
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] s,
  output logic         cout
);

  localparam int WORDS = W / SLICE_W;
  localparam int IW    = idxWidth(WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  if ((W % SLICE_W) != 0 || W < SLICE_W) begin : gen_bad_width
    $error("seq_wide_adder: W (%0d) must be a multiple of 32 and at least 32", W);
  end

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic [W-1:0]      s_q, s_d;

  logic [IW+SLICE_LG-1:0] sliceLsb;
  logic [SLICE_W-1:0]     wordA;
  logic [SLICE_W-1:0]     wordB;
  logic [SLICE_W-1:0]     sumWord;
  logic                   carryOut;

  assign sliceLsb = {idx_q, {SLICE_LG{1'b0}}};
  assign wordA    = a_q[sliceLsb +: SLICE_W];
  assign wordB    = b_q[sliceLsb +: SLICE_W];

  csa32bits u_csa (
    .a    (wordA),
    .b    (wordB),
    .cin  (carry_q),
    .s    (sumWord),
    .cout (carryOut)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
    end
  end

  // Operands are only loaded in IDLE, so they stay frozen for the whole run.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d[sliceLsb +: SLICE_W] = sumWord;
        carry_d = carryOut;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign s         = s_q;
  assign cout      = carry_q;

endmodule

// File: tb/tb_seq_wide_adder.sv
// Bench for seq_wide_adder: W = 32, 64 and 128 instances run side by side, each
// with directed carry, backpressure, reset and back-to-back cases plus a random run.
module tb_seq_wide_adder;

  localparam int RANDOM_OPS  = 1000;
  localparam int CYCLE_LIMIT = 60000;

  logic clk = 1'b0;
  int   cycle  = 0;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  for (genvar g = 0; g < 3; g++) begin : gen_w
    localparam int W     = 32 << g;
    localparam int WORDS = W / 32;
    typedef logic [W:0] word_t;

    logic         rst_n;
    logic         inValid;
    logic         inReady;
    logic         cin;
    logic         outValid;
    logic         outReady;
    logic         cout;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s;

    word_t expQ [$];
    int    acceptQ [$];
    int    readyMode     = 1;
    bit    b2b           = 1'b0;
    int    prevAccept    = -1;
    int    lastAccept    = -1;
    int    lastHandshake = -1;
    int    acceptCount   = 0;
    int    firstValid    = 0;
    bit    prevOutValid  = 1'b0;
    bit    done          = 1'b0;

    seq_wide_adder #(.W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (inValid),
      .in_ready  (inReady),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (outValid),
      .out_ready (outReady),
      .s         (s),
      .cout      (cout)
    );

    function automatic word_t refSum(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      return {1'b0, x} + {1'b0, y} + word_t'(c);
    endfunction

    function automatic logic [W-1:0] randVal();
      logic [W-1:0] v;
      for (int i = 0; i < WORDS; i++) v[32*i +: 32] = $urandom();
      return v;
    endfunction

    task automatic checkValue(input string name, input word_t act, input word_t exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL W=%0d %s: got %h, expected %h", W, name, act, exp);
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
      checkValue(name, word_t'(act), word_t'(exp));
    endtask

    task automatic checkOutput();
      word_t expv;
      int    acc;
      if (expQ.size() == 0) begin
        checks++;
        $display("[TB] FAIL W=%0d unexpected result: got %h, expected no output", W, {cout, s});
      end else begin
        expv = expQ.pop_front();
        acc  = acceptQ.pop_front();
        checkValue("sum", {cout, s}, expv);
        checkValue("latency", word_t'(firstValid - acc), word_t'(WORDS + 1));
        lastHandshake = cycle;
      end
    endtask

    task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
      int waited = 0;
      a = av;
      b = bv;
      cin = cv;
      inValid = 1'b1;
      @(negedge clk);
      while (inReady !== 1'b1 && waited < 400) begin
        @(negedge clk);
        waited++;
      end
      if (inReady !== 1'b1) begin
        checks++;
        $display("[TB] FAIL W=%0d accept timeout: in_ready=%b, expected 1", W, inReady);
      end
      @(posedge clk);
      #1;
      inValid = 1'b0;
    endtask

    task automatic waitIdle();
      int waited = 0;
      while ((expQ.size() != 0 || inReady !== 1'b1) && waited < 400) begin
        @(negedge clk);
        waited++;
      end
      if (expQ.size() != 0 || inReady !== 1'b1) begin
        checks++;
        $display("[TB] FAIL W=%0d drain timeout: %0d results pending, expected 0", W, expQ.size());
      end
      @(posedge clk);
      #1;
    endtask

    // out_ready policy: 0 = held low, 1 = held high, otherwise random stalls.
    always @(posedge clk) begin
      #2;
      case (readyMode)
        0:       outReady = 1'b0;
        1:       outReady = 1'b1;
        default: outReady = 1'($urandom_range(0, 1));
      endcase
    end

    always @(negedge clk) begin
      if (rst_n === 1'b1 && inValid === 1'b1 && inReady === 1'b1) begin
        expQ.push_back(refSum(a, b, cin));
        acceptQ.push_back(cycle);
        if (b2b && prevAccept >= 0)
          checkValue("b2b spacing", word_t'(cycle - prevAccept), word_t'(WORDS + 2));
        prevAccept = cycle;
        lastAccept = cycle;
        acceptCount++;
      end
    end

    always @(negedge clk) begin
      if (rst_n === 1'b1 && outValid === 1'b1) begin
        if (!prevOutValid) firstValid = cycle;
        if (outReady === 1'b1) checkOutput();
      end
      prevOutValid = (rst_n === 1'b1) && (outValid === 1'b1);
    end

    initial begin : stim
      logic [W-1:0] av;
      logic [W-1:0] bv;
      logic         cv;
      word_t        expv;
      int           seen;
      int           savedCount;

      rst_n = 1'b0;
      inValid = 1'b0;
      a = '0;
      b = '0;
      cin = 1'b0;
      readyMode = 1;
      repeat (2) @(posedge clk);
      #1;
      checkBit("reset out_valid", outValid, 1'b0);
      checkValue("reset s/cout", {cout, s}, word_t'(0));
      checkBit("reset in_ready", inReady, 1'b1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Low word all ones plus one: the carry must land in word 1.
      av = '0;
      av[31:0] = 32'hFFFF_FFFF;
      bv = '0;
      bv[0] = 1'b1;
      applyStimulus(av, bv, 1'b0);
      @(negedge clk);
      checkBit("in_ready during run", inReady, 1'b0);
      waitIdle();

      av = '1;
      applyStimulus(av, '0, 1'b1);
      waitIdle();

      // Backpressure with new operands offered throughout the stall.
      readyMode = 0;
      av = randVal();
      bv = randVal();
      cv = 1'($urandom_range(0, 1));
      expv = refSum(av, bv, cv);
      applyStimulus(av, bv, cv);
      savedCount = acceptCount;
      a = randVal();
      b = randVal();
      cin = ~cv;
      inValid = 1'b1;
      seen = 0;
      @(negedge clk);
      while (outValid !== 1'b1 && seen < 50) begin
        @(negedge clk);
        seen++;
      end
      repeat (5) begin
        checkBit("stall out_valid", outValid, 1'b1);
        checkValue("stall sum", {cout, s}, expv);
        checkBit("stall in_ready", inReady, 1'b0);
        @(posedge clk);
        #1;
        a = randVal();
        b = randVal();
        cin = ~cin;
        @(negedge clk);
      end
      checkValue("stall no capture", word_t'(acceptCount), word_t'(savedCount));
      @(posedge clk);
      #1;
      readyMode = 1;
      seen = 0;
      while (acceptCount == savedCount && seen < 20) begin
        @(negedge clk);
        seen++;
      end
      @(posedge clk);
      #1;
      inValid = 1'b0;
      checkValue("capture after release", word_t'(lastAccept), word_t'(lastHandshake + 1));
      waitIdle();

      // Abort an operation one word into the run.
      applyStimulus(randVal(), randVal(), 1'b1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checkBit("abort out_valid", outValid, 1'b0);
      checkValue("abort s/cout", {cout, s}, word_t'(0));
      expQ.delete();
      acceptQ.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      checkBit("in_ready after release", inReady, 1'b1);
      seen = 0;
      repeat (WORDS + 4) begin
        @(negedge clk);
        if (outValid === 1'b1) seen++;
      end
      checkValue("no aborted result", word_t'(seen), word_t'(0));

      readyMode = 1;
      prevAccept = -1;
      b2b = 1'b1;
      repeat (3) applyStimulus(randVal(), randVal(), 1'($urandom_range(0, 1)));
      b2b = 1'b0;
      waitIdle();

      readyMode = 2;
      for (int i = 0; i < RANDOM_OPS; i++) begin
        av = randVal();
        case ($urandom_range(0, 3))
          0:       bv = ~av;
          1:       bv = '0;
          default: bv = randVal();
        endcase
        cv = 1'($urandom_range(0, 1));
        applyStimulus(av, bv, cv);
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
      end
      waitIdle();
      readyMode = 1;
      $display("[TB] W=%0d: %0d operations accepted", W, acceptCount);
      done = 1'b1;
    end
  end

  initial begin : finisher
    while (!(gen_w[0].done && gen_w[1].done && gen_w[2].done) && cycle < CYCLE_LIMIT)
      @(posedge clk);
    if (!(gen_w[0].done && gen_w[1].done && gen_w[2].done)) begin
      checks++;
      $display("[TB] FAIL global timeout: reached cycle %0d, expected completion before %0d", cycle, CYCLE_LIMIT);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
